// File: rtl/snax_csr_manager_if.sv
// CSR request/response bus between an issuer (master) and snax_csr_manager (slave).
// Signal names carry the manager-side direction suffixes so both ends use one vocabulary.
interface snax_csr_manager_if;
    logic [31:0] csr_req_bits_data_i;
    logic [31:0] csr_req_bits_addr_i;
    logic        csr_req_bits_write_i;
    logic        csr_req_valid_i;
    logic        csr_req_ready_o;
    logic [31:0] csr_rsp_bits_data_o;
    logic        csr_rsp_valid_o;
    logic        csr_rsp_ready_i;

    modport master (
        output csr_req_bits_data_i,
        output csr_req_bits_addr_i,
        output csr_req_bits_write_i,
        output csr_req_valid_i,
        input  csr_req_ready_o,
        input  csr_rsp_bits_data_o,
        input  csr_rsp_valid_o,
        output csr_rsp_ready_i
    );

    modport slave (
        input  csr_req_bits_data_i,
        input  csr_req_bits_addr_i,
        input  csr_req_bits_write_i,
        input  csr_req_valid_i,
        output csr_req_ready_o,
        output csr_rsp_bits_data_o,
        output csr_rsp_valid_o,
        input  csr_rsp_ready_i
    );
endinterface

// File: rtl/snax_csr_manager.sv
// CSR staging bank with launch snapshot to the accelerator; reads answer 1 cycle after accept.
// Backpressure: requests stall while a response is blocked or a relaunch waits for the accelerator.
module snax_csr_manager #(
    parameter int unsigned NumRwCsr = 8,
    parameter int unsigned NumRoCsr = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    snax_csr_manager_if.slave      csr,
    output logic [NumRwCsr*32-1:0] acc_csr_o,
    output logic                   acc_cfg_valid_o,
    input  logic                   acc_cfg_ready_i,
    input  logic [NumRoCsr*32-1:0] ro_csr_i
);
    localparam int unsigned LaunchIdx = NumRwCsr - 1;

    typedef enum logic {
        IDLE   = 1'b0,
        LAUNCH = 1'b1
    } state_e;

    state_e                 state_q, state_d;
    logic [31:0]            staging_q [NumRwCsr];
    logic [31:0]            staging_d [NumRwCsr];
    logic [NumRwCsr*32-1:0] acc_csr_q, acc_csr_d;
    logic                   rsp_valid_q, rsp_valid_d;
    logic [31:0]            rsp_data_q, rsp_data_d;

    logic        rsp_stall;
    logic        wr_launch_idx;
    logic        req_ready;
    logic        req_accept;
    logic        wr_accept;
    logic        rd_accept;
    logic        launch_fire;
    logic        cfg_fire;
    logic [31:0] rd_data;

    always_comb begin
        rsp_stall     = rsp_valid_q && !csr.csr_rsp_ready_i;
        wr_launch_idx = csr.csr_req_bits_write_i
                        && (csr.csr_req_bits_addr_i == 32'(LaunchIdx));
    end

    // FSM output process: launch handshake and request admission.
    always_comb begin
        acc_cfg_valid_o = (state_q == LAUNCH);
        req_ready       = !rsp_stall && !(wr_launch_idx && (state_q == LAUNCH));
    end

    always_comb begin
        req_accept  = csr.csr_req_valid_i && req_ready;
        wr_accept   = req_accept && csr.csr_req_bits_write_i;
        rd_accept   = req_accept && !csr.csr_req_bits_write_i;
        launch_fire = wr_accept && wr_launch_idx && csr.csr_req_bits_data_i[0]
                      && (state_q == IDLE);
        cfg_fire    = acc_cfg_valid_o && acc_cfg_ready_i;
    end

    // FSM next-state process.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (launch_fire) state_d = LAUNCH;
            LAUNCH:  if (cfg_fire) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Writes to read-only or unmapped addresses match no staging slot and fall away.
    always_comb begin
        for (int unsigned i = 0; i < NumRwCsr; i++) begin
            staging_d[i] = staging_q[i];
            if (wr_accept && (csr.csr_req_bits_addr_i == 32'(i))) begin
                staging_d[i] = csr.csr_req_bits_data_i;
            end
        end
    end

    // The snapshot takes staging_d so the launch word itself lands in slot L.
    always_comb begin
        acc_csr_d = acc_csr_q;
        if (launch_fire) begin
            for (int unsigned i = 0; i < NumRwCsr; i++) begin
                acc_csr_d[i*32 +: 32] = staging_d[i];
            end
        end
    end

    always_comb begin
        rd_data = '0;
        for (int unsigned i = 0; i < LaunchIdx; i++) begin
            if (csr.csr_req_bits_addr_i == 32'(i)) rd_data = staging_q[i];
        end
        if (csr.csr_req_bits_addr_i == 32'(LaunchIdx)) begin
            rd_data = {31'b0, (state_q == LAUNCH)};
        end
        for (int unsigned i = 0; i < NumRoCsr; i++) begin
            if (csr.csr_req_bits_addr_i == 32'(NumRwCsr + i)) rd_data = ro_csr_i[i*32 +: 32];
        end
    end

    // A read accepted in the pop cycle reloads the buffer, keeping full throughput.
    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        if (rd_accept) begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = rd_data;
        end else if (csr.csr_rsp_ready_i) begin
            rsp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            acc_csr_q   <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            for (int unsigned i = 0; i < NumRwCsr; i++) begin
                staging_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            acc_csr_q   <= acc_csr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            for (int unsigned i = 0; i < NumRwCsr; i++) begin
                staging_q[i] <= staging_d[i];
            end
        end
    end

    always_comb begin
        csr.csr_req_ready_o     = req_ready;
        csr.csr_rsp_valid_o     = rsp_valid_q;
        csr.csr_rsp_bits_data_o = rsp_data_q;
        acc_csr_o               = acc_csr_q;
    end
endmodule

// File: tb/tb_snax_csr_manager.sv
// Bench for snax_csr_manager: directed scenarios plus random traffic against a CSR-map model,
// with read responses checked by a queue-based monitor.
module tb_snax_csr_manager;
    localparam int NRW = 8;
    localparam int NRO = 2;
    localparam int L   = NRW - 1;

    logic               clk_i = 1'b0;
    logic               rst_ni = 1'b0;
    logic               acc_cfg_ready_i = 1'b0;
    logic               acc_cfg_valid_o;
    logic [NRW*32-1:0]  acc_csr_o;
    logic [NRO*32-1:0]  ro_csr_i = '0;

    snax_csr_manager_if csr_if ();

    snax_csr_manager #(.NumRwCsr(NRW), .NumRoCsr(NRO)) dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .csr             (csr_if.slave),
        .acc_csr_o       (acc_csr_o),
        .acc_cfg_valid_o (acc_cfg_valid_o),
        .acc_cfg_ready_i (acc_cfg_ready_i),
        .ro_csr_i        (ro_csr_i)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int failures = 0;

    // Reference view of the CSR map
    logic [31:0] m_stage [NRW];
    logic [31:0] m_snap  [NRW];
    bit          m_busy;
    bit          m_pending;
    logic [31:0] sb_q [$];
    int          busy_cycles;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NRW; i++) begin
            m_stage[i] = '0;
            m_snap[i]  = '0;
        end
        m_busy    = 1'b0;
        m_pending = 1'b0;
        sb_q.delete();
    endtask

    // One bus cycle: drive at negedge, check against the model, then advance the model past the edge.
    task automatic step(input bit v, input bit w, input logic [31:0] a, input logic [31:0] d,
                        input bit rr, input bit cr, output bit acc);
        bit          exp_ready;
        logic [31:0] e;
        @(negedge clk_i);
        csr_if.csr_req_valid_i      = v;
        csr_if.csr_req_bits_write_i = w;
        csr_if.csr_req_bits_addr_i  = a;
        csr_if.csr_req_bits_data_i  = d;
        csr_if.csr_rsp_ready_i      = rr;
        acc_cfg_ready_i             = cr;
        #1;
        exp_ready = !(m_pending && !rr) && !(w && (a == L) && m_busy);
        check32("req_ready", {31'b0, csr_if.csr_req_ready_o}, {31'b0, exp_ready});
        check32("cfg_valid", {31'b0, acc_cfg_valid_o}, {31'b0, m_busy});
        check32("rsp_valid", {31'b0, csr_if.csr_rsp_valid_o}, {31'b0, m_pending});
        if (m_busy) begin
            busy_cycles++;
            for (int i = 0; i < NRW; i++) check32("acc_csr", acc_csr_o[i*32 +: 32], m_snap[i]);
        end
        acc = v && exp_ready;
        if (acc && !w) begin
            if (a < L)               e = m_stage[a];
            else if (a == L)         e = {31'b0, m_busy};
            else if (a < NRW + NRO)  e = ro_csr_i[(a - NRW)*32 +: 32];
            else                     e = 32'h0;
            sb_q.push_back(e);
        end
        @(posedge clk_i);
        #1;
        if (m_busy && cr) m_busy = 1'b0;
        if (acc && !w) m_pending = 1'b1;
        else if (rr)   m_pending = 1'b0;
        if (acc && w && (a < NRW)) begin
            m_stage[a] = d;
            if ((a == L) && d[0] && !m_busy) begin
                for (int i = 0; i < NRW; i++) m_snap[i] = m_stage[i];
                m_busy = 1'b1;
            end
        end
    endtask

    // Response monitor: every presented response must match the oldest outstanding read.
    initial begin
        forever begin
            @(negedge clk_i);
            #2;
            if (rst_ni && csr_if.csr_rsp_valid_o) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL rsp_unexpected actual=%h expected=no_response", csr_if.csr_rsp_bits_data_o);
                end else begin
                    check32("rsp_data", csr_if.csr_rsp_bits_data_o, sb_q[0]);
                    if (csr_if.csr_rsp_ready_i) void'(sb_q.pop_front());
                end
            end
        end
    end

    initial begin
        #500000;
        failures++;
        $display("FAIL watchdog actual=timeout expected=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        bit          a;
        logic [31:0] addr, data;
        int          r;

        csr_if.csr_req_valid_i      = 1'b0;
        csr_if.csr_req_bits_write_i = 1'b0;
        csr_if.csr_req_bits_addr_i  = '0;
        csr_if.csr_req_bits_data_i  = '0;
        csr_if.csr_rsp_ready_i      = 1'b1;
        model_reset();
        busy_cycles = 0;

        #3;
        check32("rst_cfg_valid", {31'b0, acc_cfg_valid_o}, 32'h0);
        check32("rst_rsp_valid", {31'b0, csr_if.csr_rsp_valid_o}, 32'h0);
        check32("rst_rsp_data", csr_if.csr_rsp_bits_data_o, 32'h0);
        for (int i = 0; i < NRW; i++) check32("rst_acc_csr", acc_csr_o[i*32 +: 32], 32'h0);
        #9 rst_ni = 1'b1;

        // Write then read back; the write itself must not respond.
        step(1, 1, 3, 32'hDEADBEEF, 1, 1, a);
        step(1, 0, 3, 32'h0, 1, 1, a);
        check32("rd3_latency", {31'b0, csr_if.csr_rsp_valid_o}, 32'h1);
        check32("rd3_data", csr_if.csr_rsp_bits_data_o, 32'hDEADBEEF);
        step(0, 0, 0, 0, 1, 1, a);

        // Launch held off by the accelerator for three cycles.
        step(1, 1, 0, 32'h11, 1, 1, a);
        busy_cycles = 0;
        step(1, 1, L, 32'h1, 1, 0, a);
        step(0, 0, 0, 0, 1, 0, a);
        check32("launch_word0", acc_csr_o[31:0], 32'h11);
        check32("launch_word7", acc_csr_o[255:224], 32'h1);
        step(1, 0, L, 0, 1, 0, a);
        check32("rd_launch_status", csr_if.csr_rsp_bits_data_o, 32'h1);
        step(0, 0, 0, 0, 1, 0, a);
        step(0, 0, 0, 0, 1, 1, a);
        step(0, 0, 0, 0, 1, 0, a);
        check32("launch_len", busy_cycles, 4);

        // Staging write during launch, relaunch stalls until the handshake.
        step(1, 1, L, 32'h1, 1, 0, a);
        step(1, 1, 0, 32'h22, 1, 0, a);
        check32("stage_in_launch_acc", {31'b0, a}, 32'h1);
        check32("snapshot_held", acc_csr_o[31:0], 32'h11);
        step(1, 1, L, 32'h1, 1, 0, a);
        check32("relaunch_stall0", {31'b0, a}, 32'h0);
        step(1, 1, L, 32'h1, 1, 0, a);
        check32("relaunch_stall1", {31'b0, a}, 32'h0);
        step(1, 1, L, 32'h1, 1, 1, a);
        check32("relaunch_stall_hs", {31'b0, a}, 32'h0);
        step(1, 1, L, 32'h1, 1, 0, a);
        check32("relaunch_acc", {31'b0, a}, 32'h1);
        check32("relaunch_word0", acc_csr_o[31:0], 32'h22);
        step(0, 0, 0, 0, 1, 1, a);
        step(0, 0, 0, 0, 1, 1, a);

        // Blocked response holds data and stalls requests; release with a back-to-back read.
        step(1, 0, 3, 0, 0, 1, a);
        for (int k = 0; k < 5; k++) begin
            step(1, 0, 0, 0, 0, 1, a);
            check32("blocked_stall", {31'b0, a}, 32'h0);
            check32("blocked_data", csr_if.csr_rsp_bits_data_o, 32'hDEADBEEF);
        end
        step(1, 0, 0, 0, 1, 1, a);
        check32("b2b_acc", {31'b0, a}, 32'h1);
        check32("b2b_valid", {31'b0, csr_if.csr_rsp_valid_o}, 32'h1);
        check32("b2b_data", csr_if.csr_rsp_bits_data_o, 32'h22);
        step(0, 0, 0, 0, 1, 1, a);

        // Read-only and unmapped addresses.
        ro_csr_i = {32'h1234_5678, 32'h0000_CAFE};
        step(1, 0, 8, 0, 1, 1, a);
        check32("ro_read", csr_if.csr_rsp_bits_data_o, 32'h0000CAFE);
        step(1, 0, 20, 0, 1, 1, a);
        check32("oor_read", csr_if.csr_rsp_bits_data_o, 32'h0);
        step(1, 1, 9, 32'hFFFF_FFFF, 1, 1, a);
        check32("ro_write_norsp", {31'b0, csr_if.csr_rsp_valid_o}, 32'h0);
        step(1, 0, 9, 0, 1, 1, a);
        check32("ro_unchanged", csr_if.csr_rsp_bits_data_o, 32'h12345678);
        step(0, 0, 0, 0, 1, 1, a);

        // Asynchronous reset mid-launch with a response pending.
        step(1, 1, 0, 32'h55, 1, 0, a);
        step(1, 1, L, 32'h1, 1, 0, a);
        step(1, 0, 0, 0, 0, 0, a);
        step(0, 0, 0, 0, 0, 0, a);
        #2 rst_ni = 1'b0;
        #1;
        check32("arst_cfg_valid", {31'b0, acc_cfg_valid_o}, 32'h0);
        check32("arst_rsp_valid", {31'b0, csr_if.csr_rsp_valid_o}, 32'h0);
        check32("arst_rsp_data", csr_if.csr_rsp_bits_data_o, 32'h0);
        for (int i = 0; i < NRW; i++) check32("arst_acc_csr", acc_csr_o[i*32 +: 32], 32'h0);
        model_reset();
        @(posedge clk_i);
        #2 rst_ni = 1'b1;
        step(0, 0, 0, 0, 1, 1, a);
        step(1, 0, 0, 0, 1, 1, a);
        check32("arst_staging", csr_if.csr_rsp_bits_data_o, 32'h0);
        step(0, 0, 0, 0, 1, 1, a);

        // Random traffic against the model.
        for (int n = 0; n < 600; n++) begin
            ro_csr_i = {$urandom, $urandom};
            r = $urandom_range(0, 15);
            if (r <= 12)      addr = 32'(r);
            else if (r == 13) addr = 32'd20;
            else if (r == 14) addr = 32'hFFFF_FFFF;
            else              addr = 32'(L);
            data = $urandom;
            step($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, addr, data,
                 $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 3, a);
        end

        for (int k = 0; k < 10; k++) begin
            if (sb_q.size() != 0 || m_busy) step(0, 0, 0, 0, 1, 1, a);
        end
        check32("drain", 32'(sb_q.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/snax_csr_manager.md
SNAX_CSR_MANAGER -- requirements
Module: snax_csr_manager

Interface
REQ-001 SHALL have parameter NumRwCsr, default 8, meaning the count of read-write CSRs at addresses 0..NumRwCsr-1 (legal range 2..32).
REQ-002 SHALL have parameter NumRoCsr, default 2, meaning the count of read-only CSRs at addresses NumRwCsr..NumRwCsr+NumRoCsr-1.
REQ-003 SHALL have port clk_i, input, 1, the single clock; all state on rising edge.
REQ-004 SHALL have port rst_ni, input, 1, reset, asynchronous, active-low.
REQ-005 SHALL have port csr_req_bits_data_i, input, 32, write data.
REQ-006 SHALL have port csr_req_bits_addr_i, input, 32, CSR index, already offset-corrected upstream.
REQ-007 SHALL have port csr_req_bits_write_i, input, 1, 1 = write, 0 = read.
REQ-008 SHALL have ports csr_req_valid_i (input, 1) and csr_req_ready_o (output, 1), the request handshake.
REQ-009 SHALL have ports csr_rsp_bits_data_o (output, 32), csr_rsp_valid_o (output, 1) and csr_rsp_ready_i (input, 1), the read-response handshake.
REQ-010 SHALL have port acc_csr_o, output, NumRwCsr*32, launched configuration snapshot, CSR i at bits [32i+31:32i].
REQ-011 SHALL have ports acc_cfg_valid_o (output, 1) and acc_cfg_ready_i (input, 1), the launch handshake to the accelerator.
REQ-012 SHALL have port ro_csr_i, input, NumRoCsr*32, live accelerator status values.

Function
REQ-013 SHALL hold a staging bank of NumRwCsr 32-bit registers; index L = NumRwCsr-1 is the launch register.
REQ-014 SHALL define accept as csr_req_valid_i && csr_req_ready_o; only accepted requests change state.
REQ-015 SHALL drive csr_req_ready_o low when csr_rsp_valid_o=1 && csr_rsp_ready_i=0, or when the request is a write to L while state=LAUNCH; otherwise high.
REQ-016 SHALL, on an accepted write to index 0..L-1, update that staging register at the next edge, without producing a response.
REQ-017 SHALL ignore writes to read-only or out-of-range addresses (at or above NumRwCsr+NumRoCsr), without producing a response.
REQ-018 SHALL, on an accepted write to L with data bit0=1 in state IDLE, copy the staging bank (with L taking the new data) into acc_csr_o and enter LAUNCH at the next edge.
REQ-019 SHALL, on an accepted write to L with data bit0=0, only store the data.
REQ-020 SHALL use FSM states IDLE and LAUNCH: IDLE->LAUNCH per REQ-018; LAUNCH->IDLE on the cycle where acc_cfg_valid_o && acc_cfg_ready_i.
REQ-021 SHALL set acc_cfg_valid_o = (state==LAUNCH) and hold acc_csr_o stable while it is high.
REQ-022 SHALL keep accepting staging writes to 0..L-1 during LAUNCH; they SHALL NOT alter acc_csr_o.
REQ-023 SHALL, on an accepted read, load a one-entry response buffer at the next edge, so read latency is exactly 1 cycle.
REQ-024 SHALL return, for a read: staging value (index 0..L-1); {31'b0, state==LAUNCH} (index L); the ro_csr_i slice sampled at the accept cycle (RO index); 32'h0 (out of range).
REQ-025 SHALL clear csr_rsp_valid_o on csr_rsp_ready_i && csr_rsp_valid_o unless a new read is accepted in the same cycle, in which case the buffer reloads and stays valid (back-to-back reads at full throughput).
REQ-026 SHALL hold csr_rsp_bits_data_o stable while csr_rsp_valid_o=1 && csr_rsp_ready_i=0.

Reset
REQ-027 SHALL, when rst_ni=0, immediately clear all staging registers, acc_csr_o, csr_rsp_bits_data_o and csr_rsp_valid_o to 0 and set state to IDLE (acc_cfg_valid_o=0), including mid-launch or with a pending response.
REQ-028 SHALL drive csr_req_ready_o=1 at the first edge after reset release.

Verification
REQ-029 SHALL be checked: write 0xDEADBEEF to index 3, then read 3 -> rsp_valid one cycle after accept, data 0xDEADBEEF, no response to the write.
REQ-030 SHALL be checked: write index 0=0x11, then index 7=0x1 (NumRwCsr=8), with acc_cfg_ready_i low 3 cycles -> acc_cfg_valid_o high 4 cycles, acc_csr_o[31:0]=0x11, [255:224]=0x1, read of 7 during launch returns 0x1.
REQ-031 SHALL be checked: during LAUNCH, write index 0=0x22 and then write index 7=0x1 -> first write accepted, acc_csr_o unchanged; second write stalls (ready=0) until the handshake, then relaunches with 0x22.
REQ-032 SHALL be checked: read with csr_rsp_ready_i held low 5 cycles -> data stable, csr_req_ready_o=0; on release, a back-to-back read in the same cycle keeps rsp_valid high.
REQ-033 SHALL be checked: read index 8 with ro_csr_i[31:0]=0xCAFE -> 0xCAFE; read index 20 -> 0x0; write index 9 -> ignored, no response.
REQ-034 SHALL be checked: assert rst_ni low mid-LAUNCH with a pending response -> acc_cfg_valid_o, csr_rsp_valid_o and acc_csr_o go to 0 asynchronously.
